// File: rtl/input_conditioner_if.sv
// Signal bundle between a raw-input source and the input conditioner.
// The master modport is the source side, which drives raw_in and observes
// the conditioned outputs. The slave modport is the conditioner side.
interface input_conditioner_if;
  logic       raw_in;
  logic       level_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] bounce_cnt;

  modport master (
    output raw_in,
    input  level_out, rise_pulse, fall_pulse, bounce_cnt
  );

  modport slave (
    input  raw_in,
    output level_out, rise_pulse, fall_pulse, bounce_cnt
  );
endinterface

// File: rtl/input_conditioner.sv
// Front-end conditioner for a bouncy asynchronous one-bit input.
// Processing order: a SYNC_STAGES-deep synchronizer, then a four-state
// debounce FSM. A new level is accepted only after DEBOUNCE_CYCLES
// consecutive stable synchronized samples. All outputs are registered.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                 clock,
  input logic                 reset,
  input_conditioner_if.slave  io
);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

  // The qualification is complete when the counter reaches its last value
  // while the new level is still present on that same sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_in;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic             abort;

  assign sync_in = sync_pipe[SYNC_STAGES-1];

  // Synchronizer shift register. This is the only logic that touches raw_in.
  always_ff @(posedge clock) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], io.raw_in};
  end

  // Debounce state, stability counter and the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic. The pulses default to 0, so each lasts exactly one
  // cycle. A WAIT state that loses its candidate level counts one bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    bcnt_d  = bcnt_q;
    abort   = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync_in) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    // The bounce counter saturates at 255 and holds there.
    if (abort && (bcnt_q != 8'hFF)) bcnt_d = bcnt_q + 8'd1;
  end

  assign io.level_out  = level_q;
  assign io.rise_pulse = rise_q;
  assign io.fall_pulse = fall_q;
  assign io.bounce_cnt = bcnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner.
// Two instances run side by side: the default configuration (S=2, D=4)
// and a short one (S=3, D=2). Every cycle, both are compared against a
// run-length reference model. Fixed vector tables and hand-written
// sequences pin down the exact latency and the boundary cases.
module tb_input_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  input_conditioner_if ifa();
  input_conditioner_if ifb();

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .io(ifa));
  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset), .io(ifb));

  int checks   = 0;
  int failures = 0;

  // Reference model. hist[i] is the raw sample taken i+1 edges ago, so the
  // debouncer sees hist[S-1]. run counts consecutive samples that differ
  // from the accepted level.
  typedef struct {
    bit [3:0] hist;
    bit       level;
    bit       rise;
    bit       fall;
    int       run;
    int       bcnt;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t m, bit rst, bit raw, int s, int d);
    mstate_t n;
    bit obs;
    n = m;
    if (rst) begin
      n.hist = '0; n.level = 0; n.rise = 0; n.fall = 0; n.run = 0; n.bcnt = 0;
      return n;
    end
    obs    = m.hist[s-1];
    n.hist = {m.hist[2:0], raw};
    n.rise = 0;
    n.fall = 0;
    if (obs == m.level) begin
      if (m.run > 0 && n.bcnt < 255) n.bcnt = n.bcnt + 1;
      n.run = 0;
    end else begin
      n.run = m.run + 1;
      if (n.run == d) begin
        n.level = obs;
        n.rise  = obs;
        n.fall  = !obs;
        n.run   = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advances one clock, steps both models with the inputs the DUTs sampled,
  // then compares all outputs just after the edge.
  task automatic tick();
    @(posedge clock);
    ma = mstep(ma, reset, ifa.raw_in, 2, 4);
    mb = mstep(mb, reset, ifb.raw_in, 3, 2);
    #1;
    chk("a_level", ifa.level_out,  ma.level);
    chk("a_rise",  ifa.rise_pulse, ma.rise);
    chk("a_fall",  ifa.fall_pulse, ma.fall);
    chk("a_bcnt",  ifa.bounce_cnt, ma.bcnt);
    chk("b_level", ifb.level_out,  mb.level);
    chk("b_rise",  ifb.rise_pulse, mb.rise);
    chk("b_fall",  ifb.fall_pulse, mb.fall);
    chk("b_bcnt",  ifb.bounce_cnt, mb.bcnt);
    if (ifa.rise_pulse && ifa.fall_pulse) chk("a_both_pulses", 1, 0);
    if (ifb.rise_pulse && ifb.fall_pulse) chk("b_both_pulses", 1, 0);
  endtask

  typedef struct {
    bit rst;
    bit raw;
    bit lvl;
    bit rise;
    bit fall;
  } vec_t;

  vec_t tv[$];

  initial begin
    ifa.raw_in = 1'b0;
    ifb.raw_in = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};

    // Vector table for instance A. It covers reset, then a rise, then a fall.
    for (int i = 0; i < 10; i++) tv.push_back('{1, 0, 0, 0, 0});
    for (int e = 1; e <= 8; e++)
      tv.push_back('{0, 1, (e >= 6), (e == 6), 0});
    for (int e = 1; e <= 8; e++)
      tv.push_back('{0, 0, (e < 6), 0, (e == 6)});

    for (int i = 0; i < tv.size(); i++) begin
      reset      = tv[i].rst;
      ifa.raw_in = tv[i].raw;
      ifb.raw_in = 1'b0;
      tick();
      chk($sformatf("tbl%0d_level", i), ifa.level_out,  tv[i].lvl);
      chk($sformatf("tbl%0d_rise",  i), ifa.rise_pulse, tv[i].rise);
      chk($sformatf("tbl%0d_fall",  i), ifa.fall_pulse, tv[i].fall);
      chk($sformatf("tbl%0d_bcnt",  i), ifa.bounce_cnt, 0);
    end

    // Short glitches on A are rejected. bounce_cnt counts them and
    // saturates at 255.
    for (int r = 0; r < 300; r++) begin
      ifa.raw_in = 1'b1; tick(); tick();
      ifa.raw_in = 1'b0; tick(); tick(); tick(); tick();
      chk("glitch_level", ifa.level_out, 0);
      if (r == 0) chk("glitch_first_bcnt", ifa.bounce_cnt, 1);
    end
    chk("glitch_sat_bcnt", ifa.bounce_cnt, 255);
    tick();
    chk("glitch_hold_bcnt", ifa.bounce_cnt, 255);

    // A reset on edge 4 of a qualification clears everything. With raw_in
    // held high, the input then re-qualifies normally.
    ifa.raw_in = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_level", ifa.level_out,  0);
    chk("rst_mid_rise",  ifa.rise_pulse, 0);
    chk("rst_mid_bcnt",  ifa.bounce_cnt, 0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rst_req_rise_e%0d", e),  ifa.rise_pulse, (e == 6));
      chk($sformatf("rst_req_level_e%0d", e), ifa.level_out,  (e >= 6));
    end
    chk("rst_req_bcnt", ifa.bounce_cnt, 0);

    // Instance B (S=3, D=2): a 1-cycle pulse is rejected, and a 2-cycle
    // pulse is accepted and then released.
    reset = 1'b1; ifa.raw_in = 1'b0; ifb.raw_in = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    ifb.raw_in = 1'b1; tick();
    ifb.raw_in = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      chk("b_short_level", ifb.level_out, 0);
    end
    chk("b_short_bcnt", ifb.bounce_cnt, 1);
    for (int e = 1; e <= 10; e++) begin
      ifb.raw_in = (e <= 2);
      tick();
      chk($sformatf("b_pulse_rise_e%0d", e),  ifb.rise_pulse, (e == 5));
      chk($sformatf("b_pulse_fall_e%0d", e),  ifb.fall_pulse, (e == 7));
      chk($sformatf("b_pulse_level_e%0d", e), ifb.level_out,  (e == 5 || e == 6));
    end

    // Random bursty stimulus with occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) ifa.raw_in = ~ifa.raw_in;
      if ($urandom_range(0, 3) == 0) ifb.raw_in = ~ifb.raw_in;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream front-end for the lab FSM. It takes an asynchronous, bouncy one-bit input, such as a pushbutton or switch, and produces a clean, synchronized, debounced level that drives the FSM's `In` port. It also provides single-cycle rise and fall pulses and a saturating count of rejected bounces for debug.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on raw_in. Legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before accepting a change. Legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the stability counter. Derived; never overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  1  asynchronous raw input.
- level_out  output  1  debounced level; connects to the FSM `In`.
- rise_pulse  output  1  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when level_out goes 1->0.
- bounce_cnt  output  8  saturating count of aborted qualifications.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values:
  - All sync flops = 0.
  - state = IDLE_LOW, stability counter = 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, bounce_cnt = 0.
- Reset mid-operation:
  - Reset overrides everything, including an in-progress qualification and a pulse being issued in that cycle.
  - If raw_in is held high through reset, the block re-qualifies it after reset deasserts and emits a normal rise_pulse.
- Synchronizer:
  - sync_in is the last stage of a SYNC_STAGES-deep shift register clocked from raw_in.
  - No logic other than the shift register touches raw_in.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
- IDLE_LOW:
  - sync_in = 1 -> WAIT_HIGH, counter <= 1.
  - Otherwise stay.
- WAIT_HIGH:
  - sync_in = 0 -> IDLE_LOW, counter <= 0, bounce_cnt increments (saturating).
  - sync_in = 1 and counter == DEBOUNCE_CYCLES-1 -> IDLE_HIGH, level_out <= 1, rise_pulse <= 1, counter <= 0.
  - Otherwise counter increments.
- IDLE_HIGH and WAIT_LOW: mirror images of IDLE_LOW and WAIT_HIGH, with sync_in inverted. Completion sets level_out <= 0 and fall_pulse <= 1.
- Pulses:
  - rise_pulse and fall_pulse are high for exactly one cycle.
  - They are never asserted together.
  - Each pulse coincides with the first cycle of the new level_out value.
- Latency:
  - Number the rising edge that first samples a stable new raw_in value as edge 1.
  - level_out and the pulse update on edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - With defaults this is edge 6.
- Glitch rejection: any raw_in excursion shorter than DEBOUNCE_CYCLES cycles (after synchronization) never changes level_out.
- bounce_cnt:
  - Increments once per abort, from either WAIT state.
  - Saturates at 255 and holds; it does not wrap.
  - Cleared only by reset.
- Counter width: CNT_W must hold DEBOUNCE_CYCLES-1 without overflow. The counter is never compared against values outside its range.
- Output stability: level_out changes only at the completion transitions.

Test Plan:
1. Reset with raw_in = 0, hold 10 cycles -> level_out = 0, pulses = 0, bounce_cnt = 0 throughout.
2. After reset, raw_in 0->1 sampled on edge 1 and held -> level_out = 1 and rise_pulse = 1 on edge 6 only; rise_pulse = 0 on edge 7; level_out stays 1.
3. From level 1, raw_in 1->0 held -> fall_pulse for one cycle on edge 6 after the change; level_out = 0 from then on.
4. From level 0, raw_in high for 2 cycles then low -> level_out stays 0, no pulses, bounce_cnt = 1. Repeat 300 times -> bounce_cnt = 255 and holds.
5. raw_in high continuously; assert reset for 1 cycle on edge 4 of a qualification -> outputs 0 the cycle after reset; rise_pulse re-issued at 6 edges after reset deasserts; bounce_cnt = 0.
6. DEBOUNCE_CYCLES = 2, SYNC_STAGES = 3 -> level_out rises on edge 5. A 1-cycle pulse is rejected; a 2-cycle pulse is accepted, followed by a fall after the release.
